sprite_mem_arbiter: RTL and testbench
=====================================

# sprite_mem_arbiter

Round-robin arbiter that shares the single on-chip sprite/background memory read port between the game's drawing clients (doodle sprite, platforms, monsters, score digits). It sits between those requesters and the memory, issues one read per cycle, and returns each read result to the requester that issued it. While the game controller pauses the playfield, the arbiter stops issuing new reads and drains reads already in flight.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 19, memory word address width
- DATA_W, 16, memory data width
- MEM_LAT, 2, fixed memory read latency in cycles from mem_rd to mem_rdata valid (1..4)

Ports:
- Clk  in  1  system clock; all state on posedge
- Reset  in  1  synchronous, active-high
- req  in  N_REQ  per-requester read request, level
- addr  in  N_REQ*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W]
- hold  in  1  block new grants (game not in play/drop)
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
- mem_rd  out  1  registered read strobe to memory
- mem_addr  out  ADDR_W  registered read address
- mem_rdata  in  DATA_W  memory read data
- rdata  out  DATA_W  registered return data
- rvalid  out  N_REQ  one-hot, registered; marks which requester owns rdata
- busy  out  1  high while any read is issued or in flight

## Operation
- Arbitration is combinational each cycle. Search starts at rr_ptr and runs upward with wrap-around. The first i with req[i]=1 gets gnt[i]=1. If hold=1 or no req is high, gnt=0.
- At most one gnt bit is high per cycle.
- On the edge ending a cycle with gnt[i]=1:
  - mem_rd<=1 and mem_addr<=addr[i].
  - The tag i enters a MEM_LAT-deep tag pipeline.
  - rr_ptr<=(i+1) mod N_REQ.
- With no grant: mem_rd<=0, mem_addr holds its value, rr_ptr is unchanged.
- Requester handshake: a requester holds req and addr stable until it sees gnt. In the cycle after gnt it may present a new address with req still high (back-to-back) or drop req.
- Return path: when the tag pipeline output is valid, rdata<=mem_rdata and rvalid<=onehot(tag) on the same edge. Otherwise rvalid<=0 and rdata holds its value.
- busy = mem_rd OR any tag-pipeline stage valid OR rvalid pending.
- hold rising mid-operation: grants stop immediately in that cycle. All in-flight reads still return rvalid. busy falls after the last rvalid.
- Requesters that drop req never lose rr_ptr fairness. The pointer moves only on an actual grant.
- A requester whose address field changes while req=1 and gnt=0 is legal. The value sampled is the one present in the grant cycle.
- Reset mid-operation clears the tag pipeline. No rvalid is produced for reads issued before Reset.

## Timing
- Reset values:
  - gnt=0 (because no req is accepted during Reset)
  - mem_rd=0, mem_addr=0
  - rdata=0, rvalid=0
  - busy=0
  - rr_ptr=0, all tag stages invalid
- Latency: gnt in cycle t, mem_rd/mem_addr in cycle t+1, mem_rdata sampled at the end of cycle t+MEM_LAT, rdata/rvalid in cycle t+MEM_LAT+1.
  - With MEM_LAT=2, the return is 3 cycles after gnt.
- Throughput: one grant and one return per cycle sustained.
- Simultaneous requests are resolved only by rr_ptr. Requester index order breaks ties only through the search direction.
- hold and req are sampled in the same cycle. hold=1 wins.

## Test plan
- Single requester: Reset then req[2]=1, addr[2]=0x00123 for one cycle.
  - Required: gnt=0100 in that cycle (t), mem_rd=1/mem_addr=0x00123 at t+1, rvalid=0100 with rdata=mem_rdata at t+3 (MEM_LAT=2).
- All four req held high for 8 cycles after Reset.
  - Required: grant order 0,1,2,3,0,1,2,3, one per cycle, and rvalid returns in the same order 3 cycles later.
- Back-to-back from one requester: req[1] held for 4 cycles with addresses 10,11,12,13.
  - Required: four consecutive grants, mem_addr 10..13 on consecutive cycles, four consecutive rvalid=0010 with matching data.
- hold: 4 reads in flight, then hold=1 with all req high.
  - Required: gnt stays 0, the 4 pending rvalid still appear, busy drops to 0 the cycle after the last rvalid. Releasing hold resumes at the rr_ptr left by the last grant.
- Reset mid-flight: assert Reset one cycle after two grants.
  - Required: no rvalid follows, all outputs at reset values next cycle, the next grant goes to the lowest-index active requester.

Source files
------------

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter sharing the sprite/background memory read port between drawing clients.
// One read is issued per cycle; a tag pipeline routes each result back to its requester.
module sprite_mem_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic                    hold,
    output logic [N_REQ-1:0]        gnt,
    output logic                    mem_rd,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        rvalid,
    output logic                    busy
);
    localparam int unsigned TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = TAG_W + 1;

    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               gnt_any;
    logic [TAG_W-1:0]   gnt_idx;

    logic               mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [TAG_W-1:0]   tag_q [MEM_LAT];
    logic [TAG_W-1:0]   tag_d [MEM_LAT];
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [N_REQ-1:0]   rvalid_q, rvalid_d;

    // Search upward from rr_ptr with wrap; first active requester wins.
    always_comb begin : p_arb
        logic [SUM_W-1:0] cand;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (cand >= SUM_W'(N_REQ)) begin
                cand = cand - SUM_W'(N_REQ);
            end
            if (!gnt_any && req[cand[TAG_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[TAG_W-1:0];
            end
        end
        if (hold || Reset) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
        gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin : p_next
        rr_ptr_d   = rr_ptr_q;
        mem_rd_d   = gnt_any;
        mem_addr_d = mem_addr_q;
        if (gnt_any) begin
            mem_addr_d = addr[gnt_idx*ADDR_W +: ADDR_W];
            rr_ptr_d   = (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        tag_vld_d[0] = gnt_any;
        tag_d[0]     = gnt_idx;
        for (int unsigned k = 1; k < MEM_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_d[k]     = tag_q[k-1];
        end

        // The last tag stage lines up with the cycle mem_rdata is valid.
        rdata_d  = rdata_q;
        rvalid_d = '0;
        if (tag_vld_q[MEM_LAT-1]) begin
            rdata_d  = mem_rdata;
            rvalid_d = N_REQ'(1) << tag_q[MEM_LAT-1];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            tag_vld_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            for (int unsigned k = 0; k < MEM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            tag_vld_q  <= tag_vld_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            for (int unsigned k = 0; k < MEM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign busy     = mem_rd_q | (|tag_vld_q) | (|rvalid_q);

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: expected issues and returns are queued at grant time and
// compared cycle by cycle against the DUT; memory is modelled with a two-cycle latency.
module tb_sprite_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 16;

    typedef struct {
        int            due;
        logic [N-1:0]  rv;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
    } iss_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   addr = '0;
    logic              hold = 1'b0;
    logic [N-1:0]      gnt;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata = '0;
    logic [DW-1:0]     rdata;
    logic [N-1:0]      rvalid;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ret_t retq[$];
    iss_t issq[$];

    sprite_mem_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .MEM_LAT(2)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .req      (req),
        .addr     (addr),
        .hold     (hold),
        .gnt      (gnt),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .busy     (busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a[15:0] ^ {13'd0, a[18:16]} ^ 16'hC35A;
    endfunction

    // Read data valid the cycle after mem_rd, sampled by the DUT at the end of that cycle.
    always @(posedge Clk) begin
        if (mem_rd) mem_rdata <= mdata(mem_addr);
    end

    task automatic do_reset();
        Reset = 1'b1;
        req   = '0;
        hold  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        retq.delete();
        issq.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        req   = 4'b1111;
        addr  = {19'h7FFFF, 19'h1234, 19'h55, 19'h3};
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt_during: got %b want 0000", gnt);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        req   = '0;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mem: got rd %b addr %h want 0/0", mem_rd, mem_addr);
        end
        checks++;
        if (rdata !== '0 || rvalid !== '0) begin
            errors++;
            $display("FAIL reset_ret: got rdata %h rvalid %b want 0/0", rdata, rvalid);
        end
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL reset_busy: got busy %b gnt %b want 0/0", busy, gnt);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_single();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        ret_t r;
        iss_t m;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req = (c == 0) ? 4'b0100 : 4'b0000;
            addr[2*AW +: AW] = 19'h00123;
            eg = (c == 0) ? 4'b0100 : 4'b0000;
            ea = 19'h00123;
            #1;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL single_gnt c%0d: got %b want %b", c, gnt, eg);
            end
            if (eg != '0) begin
                m.due = cyc + 1; m.a = ea; issq.push_back(m);
                r.due = cyc + 3; r.rv = eg; r.data = mdata(ea); retq.push_back(r);
            end
            checks++;
            if (issq.size() > 0 && issq[0].due == cyc) begin
                m = issq.pop_front();
                if (mem_rd !== 1'b1 || mem_addr !== m.a) begin
                    errors++;
                    $display("FAIL single_issue c%0d: got %b/%h want 1/%h", c, mem_rd, mem_addr, m.a);
                end
            end else if (mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL single_issue c%0d: got rd %b want 0", c, mem_rd);
            end
            checks++;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                if (rvalid !== r.rv || rdata !== r.data) begin
                    errors++;
                    $display("FAIL single_ret c%0d: got %b/%h want %b/%h", c, rvalid, rdata, r.rv, r.data);
                end
            end else if (rvalid !== '0) begin
                errors++;
                $display("FAIL single_ret c%0d: got rvalid %b want 0000", c, rvalid);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_all_req();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        ret_t r;
        iss_t m;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < N; i++) addr[i*AW +: AW] = 19'(32'h1000 + i * 32'h100 + c);
            eg = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            ea = 19'(32'h1000 + (c % 4) * 32'h100 + c);
            #1;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL all_gnt c%0d: got %b want %b", c, gnt, eg);
            end
            if (eg != '0) begin
                m.due = cyc + 1; m.a = ea; issq.push_back(m);
                r.due = cyc + 3; r.rv = eg; r.data = mdata(ea); retq.push_back(r);
            end
            checks++;
            if (issq.size() > 0 && issq[0].due == cyc) begin
                m = issq.pop_front();
                if (mem_rd !== 1'b1 || mem_addr !== m.a) begin
                    errors++;
                    $display("FAIL all_issue c%0d: got %b/%h want 1/%h", c, mem_rd, mem_addr, m.a);
                end
            end else if (mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL all_issue c%0d: got rd %b want 0", c, mem_rd);
            end
            checks++;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                if (rvalid !== r.rv || rdata !== r.data) begin
                    errors++;
                    $display("FAIL all_ret c%0d: got %b/%h want %b/%h", c, rvalid, rdata, r.rv, r.data);
                end
            end else if (rvalid !== '0) begin
                errors++;
                $display("FAIL all_ret c%0d: got rvalid %b want 0000", c, rvalid);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        ret_t r;
        iss_t m;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req = (c < 4) ? 4'b0010 : 4'b0000;
            addr[1*AW +: AW] = 19'(10 + c);
            eg = (c < 4) ? 4'b0010 : 4'b0000;
            ea = 19'(10 + c);
            #1;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL b2b_gnt c%0d: got %b want %b", c, gnt, eg);
            end
            if (eg != '0) begin
                m.due = cyc + 1; m.a = ea; issq.push_back(m);
                r.due = cyc + 3; r.rv = eg; r.data = mdata(ea); retq.push_back(r);
            end
            checks++;
            if (issq.size() > 0 && issq[0].due == cyc) begin
                m = issq.pop_front();
                if (mem_rd !== 1'b1 || mem_addr !== m.a) begin
                    errors++;
                    $display("FAIL b2b_issue c%0d: got %b/%h want 1/%h", c, mem_rd, mem_addr, m.a);
                end
            end else if (mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL b2b_issue c%0d: got rd %b want 0", c, mem_rd);
            end
            checks++;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                if (rvalid !== r.rv || rdata !== r.data) begin
                    errors++;
                    $display("FAIL b2b_ret c%0d: got %b/%h want %b/%h", c, rvalid, rdata, r.rv, r.data);
                end
            end else if (rvalid !== '0) begin
                errors++;
                $display("FAIL b2b_ret c%0d: got rvalid %b want 0000", c, rvalid);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_hold();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic          eb;
        ret_t r;
        iss_t m;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            req  = (c == 0) ? 4'b0010 : (c < 12) ? 4'b1111 : 4'b0000;
            hold = (c >= 4 && c <= 9);
            for (int i = 0; i < N; i++) addr[i*AW +: AW] = 19'(32'h40000 + i * 32'h10 + c);
            case (c)
                0:       eg = 4'b0010;
                1:       eg = 4'b0100;
                2:       eg = 4'b1000;
                3:       eg = 4'b0001;
                10:      eg = 4'b0010;
                11:      eg = 4'b0100;
                default: eg = 4'b0000;
            endcase
            ea = '0;
            for (int i = 0; i < N; i++) if (eg[i]) ea = 19'(32'h40000 + i * 32'h10 + c);
            #1;
            // Anything granted earlier and not yet returned keeps the arbiter busy.
            eb = (retq.size() > 0);
            checks++;
            if (busy !== eb) begin
                errors++;
                $display("FAIL hold_busy c%0d: got %b want %b", c, busy, eb);
            end
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL hold_gnt c%0d: got %b want %b", c, gnt, eg);
            end
            if (eg != '0) begin
                m.due = cyc + 1; m.a = ea; issq.push_back(m);
                r.due = cyc + 3; r.rv = eg; r.data = mdata(ea); retq.push_back(r);
            end
            checks++;
            if (issq.size() > 0 && issq[0].due == cyc) begin
                m = issq.pop_front();
                if (mem_rd !== 1'b1 || mem_addr !== m.a) begin
                    errors++;
                    $display("FAIL hold_issue c%0d: got %b/%h want 1/%h", c, mem_rd, mem_addr, m.a);
                end
            end else if (mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL hold_issue c%0d: got rd %b want 0", c, mem_rd);
            end
            checks++;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                if (rvalid !== r.rv || rdata !== r.data) begin
                    errors++;
                    $display("FAIL hold_ret c%0d: got %b/%h want %b/%h", c, rvalid, rdata, r.rv, r.data);
                end
            end else if (rvalid !== '0) begin
                errors++;
                $display("FAIL hold_ret c%0d: got rvalid %b want 0000", c, rvalid);
            end
            @(posedge Clk);
            #1;
        end
        hold = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        ret_t r;
        iss_t m;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            Reset = (c == 2);
            req   = (c < 3) ? 4'b1111 : (c == 4) ? 4'b0110 : 4'b0000;
            for (int i = 0; i < N; i++) addr[i*AW +: AW] = 19'(32'h2000 + i * 32'h20 + c);
            case (c)
                0:       eg = 4'b0001;
                1:       eg = 4'b0010;
                4:       eg = 4'b0010;
                default: eg = 4'b0000;
            endcase
            ea = '0;
            for (int i = 0; i < N; i++) if (eg[i]) ea = 19'(32'h2000 + i * 32'h20 + c);
            #1;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL midrst_gnt c%0d: got %b want %b", c, gnt, eg);
            end
            // Reads granted before the reset are issued but must never return.
            if (eg != '0) begin
                m.due = cyc + 1; m.a = ea; issq.push_back(m);
                if (c >= 3) begin
                    r.due = cyc + 3; r.rv = eg; r.data = mdata(ea); retq.push_back(r);
                end
            end
            if (c == 3) begin
                checks++;
                if (mem_addr !== '0 || rdata !== '0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_vals: got addr %h rdata %h busy %b want 0/0/0",
                             mem_addr, rdata, busy);
                end
            end
            checks++;
            if (issq.size() > 0 && issq[0].due == cyc) begin
                m = issq.pop_front();
                if (mem_rd !== 1'b1 || mem_addr !== m.a) begin
                    errors++;
                    $display("FAIL midrst_issue c%0d: got %b/%h want 1/%h", c, mem_rd, mem_addr, m.a);
                end
            end else if (mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL midrst_issue c%0d: got rd %b want 0", c, mem_rd);
            end
            checks++;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                if (rvalid !== r.rv || rdata !== r.data) begin
                    errors++;
                    $display("FAIL midrst_ret c%0d: got %b/%h want %b/%h", c, rvalid, rdata, r.rv, r.data);
                end
            end else if (rvalid !== '0) begin
                errors++;
                $display("FAIL midrst_ret c%0d: got rvalid %b want 0000", c, rvalid);
            end
            @(posedge Clk);
            #1;
        end
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_back_to_back();
        test_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
